// File: rtl/mips_isa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_isa_pkg
//  Description : MIPS format tags, opcode/funct constants, field positions
//                and the FIFO entry layout used by the instruction encoder.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_isa_pkg;

  // Format tag carried alongside the decoded fields
  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_BAD = 2'd3
  } fmt_e;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;

  // Field LSB positions inside the 32-bit word (shared with the parser)
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned ADDR_LSB   = 0;

  // One queued result: format-error flag, PC tag, packed word
  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [31:0] instr;
  } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/ins_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : ins_encoder_if
//  Description : Field-bundle input handshake, encoded-word output handshake,
//                flush and occupancy for the instruction encoder.
//  Revision    : 1.0  initial release
// ============================================================================
interface ins_encoder_if #(
  parameter int DEPTH = 4
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               fmt;
  logic [5:0]               opcode;
  logic [4:0]               rs;
  logic [4:0]               rt;
  logic [4:0]               rd;
  logic [4:0]               shamt;
  logic [5:0]               funct;
  logic [15:0]              immediate;
  logic [25:0]              address;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              instruction;
  logic [31:0]              p_count;
  logic                     out_err;
  logic [$clog2(DEPTH):0]   count;

  // Stimulus side: supplies fields, consumes encoded words
  modport master (
    output flush, in_valid, fmt, opcode, rs, rt, rd, shamt, funct,
           immediate, address, out_ready,
    input  in_ready, out_valid, instruction, p_count, out_err, count
  );

  // Encoder side
  modport slave (
    input  flush, in_valid, fmt, opcode, rs, rt, rd, shamt, funct,
           immediate, address, out_ready,
    output in_ready, out_valid, instruction, p_count, out_err, count
  );
endinterface
`default_nettype wire

// File: rtl/ins_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ins_fifo
//  Description : Width-parameterised synchronous FIFO with flush, full,
//                empty and exact occupancy. Read data reads 0 when empty.
//  Revision    : 1.0  initial release
// ============================================================================
module ins_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  input  wire logic                       flush,
  input  wire logic                       push,
  input  wire logic                       pop,
  input  wire logic [WIDTH-1:0]           wdata,
  output logic      [WIDTH-1:0]           rdata,
  output logic                            full,
  output logic                            empty,
  output logic      [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Flush wins over both sides; push blocked on full even if popping
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage array: written on push only, no reset needed (reads gated by empty)
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; power-of-two depth gives natural pointer wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/ins_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : ins_encoder
//  Description : Packs decoded MIPS fields into R/I/J words, tags each with a
//                sequential PC value and queues {err, pc, word} for output.
//  Revision    : 1.0  initial release
// ============================================================================
module ins_encoder
  import mips_isa_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_START = 32'h0000_0000
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  ins_encoder_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   enc_word;
  logic          enc_err;
  logic [31:0]   pc_next;
  logic          accept;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  fifo_entry_t   wr_entry;
  fifo_entry_t   rd_entry;

  assign bus.in_ready = !fifo_full && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

  // Combinational packing of the current field bundle
  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    case (fmt_e'(bus.fmt))
      FMT_R: begin
        // Opcode input is not packed; any nonzero value is flagged
        enc_word[OPCODE_LSB +: 6] = OP_RTYPE;
        enc_word[RS_LSB     +: 5] = bus.rs;
        enc_word[RT_LSB     +: 5] = bus.rt;
        enc_word[RD_LSB     +: 5] = bus.rd;
        enc_word[SHAMT_LSB  +: 5] = bus.shamt;
        enc_word[FUNCT_LSB  +: 6] = bus.funct;
        enc_err = (bus.opcode != OP_RTYPE);
      end
      FMT_I: begin
        enc_word[OPCODE_LSB +: 6]  = bus.opcode;
        enc_word[RS_LSB     +: 5]  = bus.rs;
        enc_word[RT_LSB     +: 5]  = bus.rt;
        enc_word[IMM_LSB    +: 16] = bus.immediate;
        enc_err = (bus.opcode == OP_RTYPE) || (bus.opcode == OP_J) ||
                  (bus.opcode == OP_JAL);
      end
      FMT_J: begin
        enc_word[OPCODE_LSB +: 6]  = bus.opcode;
        enc_word[ADDR_LSB   +: 26] = bus.address;
        enc_err = !((bus.opcode == OP_J) || (bus.opcode == OP_JAL));
      end
      default: begin
        // Illegal format emits a nop and flags it
        enc_word = '0;
        enc_err  = 1'b1;
      end
    endcase
  end

  // PC tag counter: restarts on reset/flush, advances by 4 per accepted word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_next <= PC_START;
    end else if (bus.flush) begin
      pc_next <= PC_START;
    end else if (accept) begin
      pc_next <= pc_next + 32'd4;
    end
  end

  assign wr_entry = '{err: enc_err, pc: pc_next, instr: enc_word};

  ins_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.flush),
    .push  (accept),
    .pop   (bus.out_ready),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.out_valid   = !fifo_empty;
  assign bus.instruction = rd_entry.instr;
  assign bus.p_count     = rd_entry.pc;
  assign bus.out_err     = rd_entry.err;
  assign bus.count       = fifo_count;
endmodule
`default_nettype wire

// File: tb/tb_ins_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ins_encoder
//  Description : Directed self-checking bench for ins_encoder with a
//                scoreboard queue of expected {err, pc, word} entries.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ins_encoder;
  import mips_isa_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] PC_START = 32'h0000_0000;
  localparam logic [31:0] PC_WRAP  = 32'hFFFF_FFFC;

  logic clk;
  logic rst_n;

  ins_encoder_if #(.DEPTH(DEPTH)) b0 ();
  ins_encoder_if #(.DEPTH(DEPTH)) b1 ();

  ins_encoder #(.DEPTH(DEPTH), .PC_START(PC_START)) dut0 (
    .clk (clk), .rst_n (rst_n), .bus (b0)
  );
  ins_encoder #(.DEPTH(DEPTH), .PC_START(PC_WRAP)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_pass;
  fifo_entry_t sb[$];
  logic [31:0] pc_model;
  logic [31:0] exp_word;
  logic        exp_err;
  logic        last_accept;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: check DUT against scoreboard at negedge, update model, step
  task automatic cycle();
    logic acc;
    logic pop;
    @(negedge clk);
    chk("out_valid", 32'(b0.out_valid), 32'(sb.size() != 0));
    chk("count", 32'(b0.count), 32'(sb.size()));
    chk("in_ready", 32'(b0.in_ready), 32'((sb.size() < DEPTH) && !b0.flush));
    if (sb.size() != 0) begin
      chk("head_instr", b0.instruction, sb[0].instr);
      chk("head_pc", b0.p_count, sb[0].pc);
      chk("head_err", 32'(b0.out_err), 32'(sb[0].err));
    end else begin
      chk("empty_instr", b0.instruction, 32'h0);
    end
    acc = b0.in_valid && (sb.size() < DEPTH) && !b0.flush;
    pop = b0.out_ready && (sb.size() != 0) && !b0.flush;
    if (b0.flush) begin
      sb.delete();
      pc_model = PC_START;
    end else begin
      if (pop) void'(sb.pop_front());
      if (acc) begin
        sb.push_back('{err: exp_err, pc: pc_model, instr: exp_word});
        pc_model = pc_model + 32'd4;
      end
    end
    last_accept = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [1:0] f, input logic [5:0] op,
                            input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sh,
                            input logic [5:0] fn, input logic [15:0] imm,
                            input logic [25:0] addr,
                            input logic [31:0] ew, input logic ee);
    b0.fmt = f; b0.opcode = op; b0.rs = rs; b0.rt = rt; b0.rd = rd;
    b0.shamt = sh; b0.funct = fn; b0.immediate = imm; b0.address = addr;
    exp_word = ew; exp_err = ee;
    b0.in_valid = 1'b1;
  endtask

  task automatic wait_accept(input int budget);
    last_accept = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (last_accept) break;
    end
    if (!last_accept) begin
      n_chk++;
      $error("FAIL accept_timeout: observed no accept expected accept within %0d cycles", budget);
    end
  endtask

  task automatic send(input logic [1:0] f, input logic [5:0] op,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh,
                      input logic [5:0] fn, input logic [15:0] imm,
                      input logic [25:0] addr,
                      input logic [31:0] ew, input logic ee);
    set_fields(f, op, rs, rt, rd, sh, fn, imm, addr, ew, ee);
    wait_accept(20);
    b0.in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) cycle();
    cycle();
    chk("drained", 32'(sb.size()), 32'h0);
  endtask

  task automatic do_flush();
    b0.flush = 1'b1;
    cycle();
    b0.flush = 1'b0;
  endtask

  // Directed sequence
  initial begin
    n_chk = 0; n_pass = 0; pc_model = PC_START;
    exp_word = '0; exp_err = 1'b0; last_accept = 1'b0;
    rst_n = 1'b0;
    b0.flush = 0; b0.in_valid = 0; b0.out_ready = 0; b0.fmt = 0; b0.opcode = 0;
    b0.rs = 0; b0.rt = 0; b0.rd = 0; b0.shamt = 0; b0.funct = 0;
    b0.immediate = 0; b0.address = 0;
    b1.flush = 0; b1.in_valid = 0; b1.out_ready = 0; b1.fmt = 0; b1.opcode = 0;
    b1.rs = 0; b1.rt = 0; b1.rd = 0; b1.shamt = 0; b1.funct = 0;
    b1.immediate = 0; b1.address = 0;

    // Reset values
    #3;
    chk("rst_out_valid", 32'(b0.out_valid), 32'h0);
    chk("rst_count", 32'(b0.count), 32'h0);
    chk("rst_instr", b0.instruction, 32'h0);
    chk("rst_pc", b0.p_count, 32'h0);
    chk("rst_err", 32'(b0.out_err), 32'h0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single R sub, visible the cycle after accept
    send(FMT_R, OP_RTYPE, 5'd8, 5'd3, 5'd2, 5'd0, FN_SUB, 16'hBEEF, 26'h3AB_CDEF,
         32'h0103_1022, 1'b0);
    chk("t1_instr", b0.instruction, 32'h0103_1022);
    chk("t1_pc", b0.p_count, 32'h0);
    chk("t1_err", 32'(b0.out_err), 32'h0);
    b0.out_ready = 1'b1;
    drain(10);

    // 2: back-to-back stream with consumer always ready
    do_flush();
    send(FMT_I, OP_ADDI, 5'd1, 5'd6, 5'd31, 5'd31, 6'h3F, 16'd10, 26'h155_5555, 32'h2026_000A, 1'b0);
    send(FMT_J, OP_J, 5'd7, 5'd7, 5'd7, 5'd7, 6'h11, 16'h1234, 26'd257, 32'h0800_0101, 1'b0);
    send(FMT_J, OP_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'd563, 32'h0C00_0233, 1'b0);
    send(FMT_I, OP_LW, 5'd30, 5'd26, 5'd1, 5'd2, 6'h05, 16'd3, 26'h0, 32'h8FDA_0003, 1'b0);
    send(FMT_I, OP_SW, 5'd5, 5'd2, 5'd9, 5'd9, 6'h09, 16'd3, 26'h0, 32'hACA2_0003, 1'b0);
    drain(10);

    // 3: fill to full with consumer stalled, hold fifth word, then release
    do_flush();
    b0.out_ready = 1'b0;
    send(FMT_R, OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd4, FN_ADD, 16'h0, 26'h0, 32'h0022_1920, 1'b0);
    send(FMT_I, OP_ORI, 5'd4, 5'd5, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0, 32'h3485_FFFF, 1'b0);
    send(FMT_I, OP_BEQ, 5'd9, 5'd10, 5'd0, 5'd0, 6'h0, 16'h8000, 26'h0, 32'h112A_8000, 1'b0);
    send(FMT_J, OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h3FF_FFFF, 32'h0BFF_FFFF, 1'b0);
    chk("t3_full_count", 32'(b0.count), 32'd4);
    chk("t3_full_in_ready", 32'(b0.in_ready), 32'h0);
    set_fields(FMT_I, OP_ADDI, 5'd2, 5'd3, 5'd0, 5'd0, 6'h0, 16'h0007, 26'h0, 32'h2043_0007, 1'b0);
    for (int i = 0; i < 3; i++) cycle();
    chk("t3_held_head", b0.instruction, 32'h0022_1920);
    chk("t3_held_pc", b0.p_count, 32'h0);
    b0.out_ready = 1'b1;
    wait_accept(10);
    b0.in_valid = 1'b0;
    drain(20);

    // 4: format errors
    do_flush();
    send(FMT_R, OP_ADDI, 5'd8, 5'd3, 5'd2, 5'd0, FN_SUB, 16'h0, 26'h0, 32'h0103_1022, 1'b1);
    send(FMT_J, OP_BEQ, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'd257, 32'h1000_0101, 1'b1);
    send(FMT_I, OP_RTYPE, 5'd1, 5'd6, 5'd0, 5'd0, 6'h0, 16'd10, 26'h0, 32'h0026_000A, 1'b1);
    send(FMT_BAD, OP_LW, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FF_FFFF, 32'h0, 1'b1);
    drain(10);

    // 5: flush with three queued entries and a competing input
    b0.out_ready = 1'b0;
    send(FMT_J, OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'd1, 32'h0800_0001, 1'b0);
    send(FMT_J, OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'd2, 32'h0800_0002, 1'b0);
    send(FMT_J, OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'd3, 32'h0800_0003, 1'b0);
    set_fields(FMT_J, OP_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'd4, 32'h0C00_0004, 1'b0);
    b0.flush = 1'b1;
    cycle();
    b0.flush = 1'b0;
    b0.in_valid = 1'b0;
    chk("t5_count", 32'(b0.count), 32'h0);
    chk("t5_out_valid", 32'(b0.out_valid), 32'h0);
    b0.out_ready = 1'b1;
    send(FMT_J, OP_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'd5, 32'h0C00_0005, 1'b0);
    chk("t5_pc_restart", b0.p_count, PC_START);
    drain(10);

    // 6: async reset pulse mid-drain, between clock edges
    b0.out_ready = 1'b0;
    send(FMT_J, OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'd6, 32'h0800_0006, 1'b0);
    send(FMT_J, OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'd7, 32'h0800_0007, 1'b0);
    b0.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 32'(b0.out_valid), 32'h0);
    chk("t6_instr", b0.instruction, 32'h0);
    chk("t6_count", 32'(b0.count), 32'h0);
    chk("t6_pc", b0.p_count, 32'h0);
    sb.delete();
    pc_model = PC_START;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(FMT_J, OP_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'd9, 32'h0C00_0009, 1'b0);
    chk("t6_pc_restart", b0.p_count, PC_START);
    drain(10);

    // 6b: PC wrap on the instance starting at 0xFFFFFFFC
    b1.fmt = FMT_J; b1.opcode = OP_J; b1.address = 26'd1;
    b1.in_valid = 1'b1; b1.out_ready = 1'b0;
    @(posedge clk); #1;
    b1.address = 26'd2;
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    @(negedge clk);
    chk("wrap_count", 32'(b1.count), 32'd2);
    chk("wrap_pc0", b1.p_count, 32'hFFFF_FFFC);
    chk("wrap_instr0", b1.instruction, 32'h0800_0001);
    b1.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap_pc1", b1.p_count, 32'h0000_0000);
    chk("wrap_instr1", b1.instruction, 32'h0800_0002);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ins_encoder.md
Name: ins_encoder

Overview:
Instruction encoder and emit queue: the inverse of the instruction-field parser.
- Accepts decoded MIPS fields (format tag plus opcode/rs/rt/rd/shamt/funct/immediate/address) over a valid/ready handshake.
- Packs them into 32-bit R/I/J words and tags each word with a sequential program-counter value.
- Buffers results in a small FIFO for the instruction memory loader or testbench stimulus generator.
- Flags field/format mismatches per word.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
PC_START, 32'h0000_0000, p_count value tagged on the first word after reset or flush.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous clear of FIFO and PC counter.
in_valid  input  1  field bundle valid.
in_ready  output  1  encoder can accept.
fmt  input  2  0=R, 1=I, 2=J, 3=illegal.
opcode  input  6  opcode field.
rs, rt, rd, shamt  input  5 each  register/shift fields.
funct  input  6  R-type function.
immediate  input  16  I-type immediate.
address  input  26  J-type target.
out_valid  output  1  head entry valid.
out_ready  input  1  consumer takes head.
instruction  output  32  encoded word at head.
p_count  output  32  PC tag of head word.
out_err  output  1  format error bit of head word.
count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty, count=0, PC counter=PC_START.
  - out_valid=0, instruction=0, p_count=0, out_err=0.
  - in_ready=1 one cycle after deassertion.
- in_ready = !full && !flush. Accept = in_valid && in_ready.
- Encoding is combinational on the inputs and registered into the FIFO on accept:
  - R: {6'h00, rs, rt, rd, shamt, funct}. The opcode input is ignored in the packed word; err=1 if opcode!=0.
  - I: {opcode, rs, rt, immediate}; err=1 if opcode is 0, 2 or 3.
  - J: {opcode, address}; err=1 if opcode is not 2 or 3.
  - fmt=3: word=32'h0000_0000 (nop), err=1.
  - Unused fields for the selected format are ignored.
- PC tag:
  - Internal pc_next is stored with each accepted word, then pc_next += 4.
  - Wraps modulo 2^32 with no error.
  - Not incremented when no accept occurs.
- Latency:
  - A word accepted at edge N appears at the head with out_valid=1 after edge N (visible cycle N+1).
  - There is no same-cycle combinational pass-through.
- Pop occurs when out_valid && out_ready. instruction/p_count/out_err hold stable while out_valid && !out_ready.
- Outputs read 0 when empty (out_valid=0).
- Push and pop in the same cycle: legal when not full. count unchanged; pointers both advance.
- Full: in_ready=0 even if a pop occurs the same cycle. No push on full; the next-cycle in_ready rises after the pop.
- Empty: out_valid=0. A pop request is ignored.
- Pointers wrap modulo DEPTH.
- flush:
  - Priority over accept and pop.
  - On the flush edge: FIFO emptied, count=0, pc_next=PC_START, out_valid=0 next cycle.
  - in_ready=0 during the flush cycle.
- rst_n asserted mid-stream: immediate clear to reset values. Partial state is not retained.
- count is exact: increments on push-only, decrements on pop-only.

Decomposition:
- Package mips_isa_pkg:
  - fmt encoding constants FMT_R/FMT_I/FMT_J/FMT_BAD.
  - Opcodes OP_RTYPE=0x00, OP_J=0x02, OP_JAL=0x03, OP_BEQ=0x04, OP_ADDI=0x08, OP_ORI=0x0D, OP_LW=0x23, OP_SW=0x2B.
  - Functs FN_ADD=0x20, FN_SUB=0x22.
  - Field bit-position constants shared with the parser.
- One sub-module, ins_fifo:
  - Width-parameterised synchronous FIFO with full/empty/count.
  - Entry = {err, p_count[31:0], instruction[31:0]}.
- Packing logic stays in ins_encoder.

Test Plan:
1. Reset, then R sub rs=8 rt=3 rd=2 shamt=0 funct=0x22; next cycle instruction=0x01031022, p_count=0x0, out_err=0.
2. Back-to-back with out_ready=1:
   - addi rs=1 rt=6 imm=10 -> 0x2026000A, p_count=0x0.
   - J address=257 -> 0x08000101, p_count=0x4.
   - jal 563 -> 0x0C000233, p_count=0x8.
   - lw rs=30 rt=26 imm=3 -> 0x8FDA0003, p_count=0xC.
   - sw rs=5 rt=2 imm=3 -> 0xACA20003, p_count=0x10.
3. out_ready=0, push 5 words with DEPTH=4:
   - in_ready drops after the 4th accept; count=4.
   - 5th word held; head stable.
   - Release out_ready: words drain in order with PC 0x0,0x4,0x8,0xC; then the 5th word follows with 0x10.
4. Format errors:
   - R with opcode=0x08 -> word opcode bits 0, out_err=1.
   - J with opcode=0x04 -> out_err=1.
   - I with opcode=0x00 -> out_err=1.
   - fmt=3 -> instruction=0x00000000, out_err=1.
5. Flush with 3 entries queued and in_valid=1:
   - Next cycle count=0, out_valid=0.
   - Flush-cycle input not accepted.
   - The next accepted word tags p_count=PC_START.
6. Async reset pulse mid-drain (between clock edges):
   - out_valid/instruction/count go to 0 immediately.
   - PC restarts at PC_START.
   - With PC_START=0xFFFFFFFC, two accepts tag 0xFFFFFFFC then 0x00000000 (wrap).
